// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - value/load inputs and display drive outputs of the segment scan controller
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [3:0]              bcd_out;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   dig_sel_n;
  logic                    dp_n;
  logic                    frame_done;

  modport master (
    output value, load, dp_in,
    input  bcd_out, blank, dig_sel_n, dp_n, frame_done
  );

  modport slave (
    input  value, load, dp_in,
    output bcd_out, blank, dig_sel_n, dp_n, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan with dark gaps; SEG_SCAN_LZB_EN enables leading-zero blanking
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1000,
  parameter int BLANK_CYC  = 8
) (
  input logic           clk,
  input logic           rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] SHOW_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {GAP, SHOW} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend_val, shad_val;
  logic [NUM_DIGITS-1:0]   pend_dp, shad_dp;
  logic [3:0]              bcd_r;
  logic                    blank_r;
  logic [NUM_DIGITS-1:0]   sel_r;
  logic                    dp_r;
  logic                    fd_r;

  logic [3:0]              cur_nib;
  logic                    lzb_dark;

  assign cur_nib = shad_val[{idx, 2'b00} +: 4];

`ifdef SEG_SCAN_LZB_EN
  logic [NUM_DIGITS:0] upper_zero;

  // upper_zero[k]: nibble k and every nibble above it are zero
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero[k] = upper_zero[k+1] && (shad_val[4*k +: 4] == 4'h0);
    end
  end

  // a leading zero stays dark unless its decimal point is requested; digit 0 always shows
  assign lzb_dark = (idx != '0) && upper_zero[idx] && !shad_dp[idx];
`else
  assign lzb_dark = 1'b0;
`endif

  // scan state machine; outputs are set on phase transitions so a lit digit never changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= GAP;
      cnt      <= '0;
      idx      <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      shad_val <= '0;
      shad_dp  <= '0;
      bcd_r    <= 4'h0;
      blank_r  <= 1'b1;
      sel_r    <= '1;
      dp_r     <= 1'b1;
      fd_r     <= 1'b0;
    end else begin
      fd_r <= 1'b0;
      if (bus.load) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp_in;
      end
      case (state)
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= SHOW;
            cnt   <= '0;
            bcd_r <= cur_nib;
            if (!lzb_dark) begin
              sel_r   <= ~(NUM_DIGITS'(1) << idx);
              blank_r <= 1'b0;
              dp_r    <= ~shad_dp[idx];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state   <= GAP;
            cnt     <= '0;
            sel_r   <= '1;
            blank_r <= 1'b1;
            dp_r    <= 1'b1;
            if (idx == IDX_LAST) begin
              idx      <= '0;
              fd_r     <= 1'b1;
              shad_val <= pend_val;
              shad_dp  <= pend_dp;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= GAP;
      endcase
    end
  end

  assign bus.bcd_out    = bcd_r;
  assign bus.blank      = blank_r;
  assign bus.dig_sel_n  = sel_r;
  assign bus.dp_n       = dp_r;
  assign bus.frame_done = fd_r;
endmodule
